// File: rtl/game_input_ctrl.sv
// Game front-panel controller: synchronises and debounces three raw buttons and runs the IDLE/RUN/PAUSE/OVER FSM.
// Latency: raw press to event is 2 cycles + DEBOUNCE_CNT ticks + 1 cycle, then outputs 1 cycle later; no backpressure.
`timescale 1ns/1ps
module game_input_ctrl #(
   parameter int DEBOUNCE_CNT = 4
) (
   input  logic       clk_in,
   input  logic       clr_n,
   input  logic       sample_tick,
   input  logic       btn_start,
   input  logic       btn_reset,
   input  logic       btn_fire,
   input  logic       game_over,
   output logic       play,
   output logic       clr,
   output logic       fire_pulse,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      OVER  = 2'd3
   } state_t;

   localparam int         NB       = 3;
   localparam int         B_START  = 0;
   localparam int         B_RESET  = 1;
   localparam int         B_FIRE   = 2;
   localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_CNT);

   logic [NB-1:0] raw;
   logic [NB-1:0] sync1_q;
   logic [NB-1:0] sync2_q;
   logic [NB-1:0] db_q;
   logic [NB-1:0] db_d;
   logic [NB-1:0] db_prev_q;
   logic [NB-1:0] press;
   logic [3:0]    cnt_q [NB];
   logic [3:0]    cnt_d [NB];

   state_t state_q;
   state_t state_d;
   logic   play_q;
   logic   play_d;
   logic   clr_q;
   logic   clr_d;
   logic   fire_q;
   logic   fire_d;

   assign raw = {btn_fire, btn_reset, btn_start};

   always_ff @(posedge clk_in or negedge clr_n) begin
      if (!clr_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

   // The counter measures consecutive ticks of disagreement; any agreeing tick restarts it.
   always_comb begin
      db_d  = db_q;
      cnt_d = cnt_q;
      for (int i = 0; i < NB; i++) begin
         if (sample_tick) begin
            if (sync2_q[i] == db_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] + 4'd1 == DB_LIMIT) begin
               db_d[i]  = ~db_q[i];
               cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_in or negedge clr_n) begin
      if (!clr_n) begin
         db_q      <= '0;
         db_prev_q <= '0;
         cnt_q     <= '{default: '0};
      end else begin
         db_q      <= db_d;
         db_prev_q <= db_q;
         cnt_q     <= cnt_d;
      end
   end

   assign press = db_q & ~db_prev_q;

   // Reset outranks game_over, which outranks start; a start coincident with reset is lost.
   always_comb begin
      state_d = state_q;
      clr_d   = 1'b0;
      fire_d  = press[B_FIRE] && (state_q == RUN);
      if (press[B_RESET]) begin
         state_d = IDLE;
         clr_d   = 1'b1;
      end else if ((state_q == RUN) && game_over) begin
         state_d = OVER;
      end else if (press[B_START]) begin
         case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = PAUSE;
            PAUSE:   state_d = RUN;
            default: begin
               state_d = IDLE;
               clr_d   = 1'b1;
            end
         endcase
      end
      play_d = (state_d == RUN);
   end

   always_ff @(posedge clk_in or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= IDLE;
         play_q  <= 1'b0;
         clr_q   <= 1'b0;
         fire_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         play_q  <= play_d;
         clr_q   <= clr_d;
         fire_q  <= fire_d;
      end
   end

   assign state      = state_q;
   assign play       = play_q;
   assign clr        = clr_q;
   assign fire_pulse = fire_q;

endmodule

// File: tb/tb_game_input_ctrl.sv
// Bench for game_input_ctrl: directed scenarios then random buttons, scored against a cycle-level reference model.
`timescale 1ns/1ps
module tb_game_input_ctrl;

   localparam int DB = 4;

   logic       clk_in      = 1'b0;
   logic       clr_n       = 1'b1;
   logic       sample_tick = 1'b0;
   logic       btn_start   = 1'b0;
   logic       btn_reset   = 1'b0;
   logic       btn_fire    = 1'b0;
   logic       game_over   = 1'b0;
   logic       play;
   logic       clr;
   logic       fire_pulse;
   logic [1:0] state;

   game_input_ctrl #(.DEBOUNCE_CNT(DB)) dut (
      .clk_in      (clk_in),
      .clr_n       (clr_n),
      .sample_tick (sample_tick),
      .btn_start   (btn_start),
      .btn_reset   (btn_reset),
      .btn_fire    (btn_fire),
      .game_over   (game_over),
      .play        (play),
      .clr         (clr),
      .fire_pulse  (fire_pulse),
      .state       (state)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic [1:0] st;
      logic       pl;
      logic       cl;
      logic       fp;
   } out_t;

   typedef struct {
      int   cyc;
      out_t o;
   } rec_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   rec_t exp_q[$];

   task automatic chk(input string name, input int got, input int expv);
      n_checks++;
      if (got != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, expv);
      end
   endtask

   // sample tick source: mode 0 = every 10th cycle, mode 1 = random
   int tick_mode = 0;
   int tick_div  = 0;
   always @(negedge clk_in) begin
      if (tick_mode == 0) begin
         tick_div    = (tick_div + 1) % 10;
         sample_tick = (tick_div == 0);
      end else begin
         sample_tick = ($urandom_range(0, 2) == 0);
      end
   end

   // Reference model: raw -> two-cycle delay -> run-length debounce -> rising-edge events -> priority rules.
   bit [2:0] m_s1, m_s2, m_db, m_dbp, m_ev;
   int       m_run [3];
   int       m_state;
   bit       m_clr, m_fire;
   out_t     m_prev = '0;
   out_t     m_cur;

   always @(posedge clk_in) begin
      cyc++;
      if (!clr_n) begin
         m_s1 = '0; m_s2 = '0; m_db = '0; m_dbp = '0;
         for (int b = 0; b < 3; b++) m_run[b] = 0;
         m_state = 0; m_clr = 0; m_fire = 0;
      end else begin
         m_ev   = m_db & ~m_dbp;
         m_clr  = 0;
         m_fire = m_ev[2] && (m_state == 1);
         if (m_ev[1]) begin
            m_state = 0;
            m_clr   = 1;
         end else if (m_state == 1 && game_over) begin
            m_state = 3;
         end else if (m_ev[0]) begin
            case (m_state)
               0: m_state = 1;
               1: m_state = 2;
               2: m_state = 1;
               default: begin m_state = 0; m_clr = 1; end
            endcase
         end
         m_dbp = m_db;
         if (sample_tick) begin
            for (int b = 0; b < 3; b++) begin
               if (m_s2[b] != m_db[b]) begin
                  m_run[b]++;
                  if (m_run[b] >= DB) begin
                     m_db[b]  = ~m_db[b];
                     m_run[b] = 0;
                  end
               end else begin
                  m_run[b] = 0;
               end
            end
         end
         m_s2 = m_s1;
         m_s1 = {btn_fire, btn_reset, btn_start};
      end
      m_cur = {2'(m_state), (m_state == 1), m_clr, m_fire};
      if (m_cur != m_prev) begin
         exp_q.push_back('{cyc, m_cur});
         m_prev = m_cur;
      end
   end

   // Monitor: every change of the output tuple must match the next predicted change, in the same cycle.
   bit   mon_en = 0;
   out_t d_prev = '0;
   out_t d_cur;
   rec_t d_rec;
   always @(negedge clk_in) begin
      if (mon_en && clr_n) begin
         d_cur = {state, play, clr, fire_pulse};
         if (d_cur != d_prev) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL sb_unexpected: cycle %0d outputs %h, no change predicted", cyc, d_cur);
            end else begin
               d_rec = exp_q.pop_front();
               if (d_rec.cyc != cyc || d_rec.o != d_cur) begin
                  n_fail++;
                  $display("FAIL sb_change: cycle %0d outputs %h, expected cycle %0d outputs %h",
                           cyc, d_cur, d_rec.cyc, d_rec.o);
               end
            end
            d_prev = d_cur;
         end
      end
   end

   int clr_seen  = 0;
   int fire_seen = 0;
   always @(negedge clk_in) begin
      if (clr_n && clr) clr_seen++;
      if (clr_n && fire_pulse) fire_seen++;
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic set_btn(input int b, input logic v);
      case (b)
         0:       btn_start = v;
         1:       btn_reset = v;
         default: btn_fire  = v;
      endcase
   endtask

   task automatic press(input int b);
      set_btn(b, 1'b1);
      cycles(70);
      set_btn(b, 1'b0);
      cycles(70);
   endtask

   int base;

   initial begin
      #2 clr_n = 1'b0;
      btn_start = 1'b1;
      btn_fire  = 1'b1;
      cycles(5);
      chk("rst_play", play, 0);
      chk("rst_state", state, 0);
      chk("rst_clr", clr, 0);
      chk("rst_fire", fire_pulse, 0);
      clr_n  = 1'b1;
      d_prev = {state, play, clr, fire_pulse};
      mon_en = 1;
      cycles(60);
      chk("release_state", state, 1);
      chk("release_play", play, 1);
      chk("release_clr_cnt", clr_seen, 0);
      chk("release_fire_dropped", fire_seen, 0);
      btn_start = 1'b0;
      btn_fire  = 1'b0;
      cycles(70);

      press(0);
      chk("pause_state", state, 2);
      chk("pause_play", play, 0);
      press(0);
      chk("resume_state", state, 1);

      base = fire_seen;
      repeat (3) press(2);
      chk("fire_run_cnt", fire_seen - base, 3);

      press(0);
      base = fire_seen;
      press(2);
      chk("fire_pause_cnt", fire_seen - base, 0);
      press(0);

      game_over = 1'b1;
      cycles(3);
      chk("over_state", state, 3);
      chk("over_play", play, 0);
      game_over = 1'b0;
      cycles(5);
      base = clr_seen;
      press(0);
      chk("over_exit_state", state, 0);
      chk("over_exit_clr", clr_seen - base, 1);

      base = fire_seen;
      press(2);
      chk("fire_idle_cnt", fire_seen - base, 0);

      btn_start = 1'b1;
      cycles(30);
      btn_start = 1'b0;
      cycles(70);
      chk("glitch_state", state, 0);

      press(0);
      chk("prio_pre_state", state, 1);
      base = clr_seen;
      btn_start = 1'b1;
      btn_reset = 1'b1;
      cycles(70);
      btn_start = 1'b0;
      btn_reset = 1'b0;
      cycles(70);
      chk("prio_state", state, 0);
      chk("prio_clr", clr_seen - base, 1);

      base = clr_seen;
      press(1);
      chk("idle_reset_clr", clr_seen - base, 1);
      chk("idle_reset_state", state, 0);

      // hold start across a reset asserted mid-debounce
      btn_start = 1'b1;
      cycles(25);
      #3 clr_n = 1'b0;
      #1 chk("async_rst_state", state, 0);
      cycles(3);
      clr_n = 1'b1;
      cycles(30);
      chk("rst_restart_state", state, 0);
      cycles(40);
      chk("rst_held_state", state, 1);
      btn_start = 1'b0;
      cycles(70);

      tick_mode = 1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk_in);
         if ($urandom_range(0, 11) == 0) btn_start = ~btn_start;
         if ($urandom_range(0, 29) == 0) btn_reset = ~btn_reset;
         if ($urandom_range(0, 9) == 0)  btn_fire  = ~btn_fire;
         if ($urandom_range(0, 14) == 0) game_over = ~game_over;
      end
      btn_start = 1'b0;
      btn_reset = 1'b0;
      btn_fire  = 1'b0;
      game_over = 1'b0;
      tick_mode = 0;
      cycles(120);
      chk("sb_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
